// File: rtl/frame_scaler_if.sv
// rtl/frame_scaler_if.sv - display-side and frame-buffer signals of frame_scaler
interface frame_scaler_if #(
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 17
);
  logic [10:0]       hcount_in;
  logic [9:0]        vcount_in;
  logic [1:0]        scale_in;
  logic [ADDR_W-1:0] addr_out;
  logic [PIX_W-1:0]  frame_buff_in;
  logic [PIX_W-1:0]  cam_out;
  logic              cam_valid_out;
  logic [10:0]       hcount_out;
  logic [9:0]        vcount_out;

  modport master (
    output hcount_in, vcount_in, scale_in, frame_buff_in,
    input  addr_out, cam_out, cam_valid_out, hcount_out, vcount_out
  );

  modport slave (
    input  hcount_in, vcount_in, scale_in, frame_buff_in,
    output addr_out, cam_out, cam_valid_out, hcount_out, vcount_out
  );
endinterface

// File: rtl/frame_scaler.sv
// rtl/frame_scaler.sv - integer upscaler (1x/2x/3x) reading a source frame buffer
// Addresses come from incremental column/row counters; pixels are realigned to the raster.
module frame_scaler #(
  parameter int PIX_W    = 8,
  parameter int SRC_W    = 320,
  parameter int SRC_H    = 240,
  parameter int ADDR_W   = 17,
  parameter int RD_LAT   = 2,
  parameter int H_ACTIVE = 1024,
  parameter int V_ACTIVE = 768
) (
  input logic           clk_in,
  input logic           rst_in,
  frame_scaler_if.slave bus
);

  localparam int HL1 = (SRC_W     < H_ACTIVE) ? SRC_W     : H_ACTIVE;
  localparam int HL2 = (SRC_W * 2 < H_ACTIVE) ? SRC_W * 2 : H_ACTIVE;
  localparam int HL3 = (SRC_W * 3 < H_ACTIVE) ? SRC_W * 3 : H_ACTIVE;
  localparam int VL1 = (SRC_H     < V_ACTIVE) ? SRC_H     : V_ACTIVE;
  localparam int VL2 = (SRC_H * 2 < V_ACTIVE) ? SRC_H * 2 : V_ACTIVE;
  localparam int VL3 = (SRC_H * 3 < V_ACTIVE) ? SRC_H * 3 : V_ACTIVE;

  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(SRC_W);
  localparam logic [10:0]       COL_MAX   = 11'(SRC_W);
  localparam logic [9:0]        ROW_MAX   = 10'(SRC_H);

  logic [1:0]        scale_q, scale_d;
  logic              sync_q, sync_d;
  logic [10:0]       col_q, col_d, col_cur;
  logic [1:0]        csub_q, csub_d, csub_cur;
  logic [9:0]        row_q, row_d;
  logic [1:0]        rsub_q, rsub_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [11:0]       h_lim;
  logic [10:0]       v_lim;
  logic [1:0]        s_last;
  logic              line_start, frame_start, in_region;

  logic [RD_LAT:0]       vld_dly_q;
  logic [RD_LAT:0][10:0] h_dly_q;
  logic [RD_LAT:0][9:0]  v_dly_q;
  logic [PIX_W-1:0]      cam_q;
  logic                  cam_vld_q;
  logic [10:0]           hout_q;
  logic [9:0]            vout_q;

  always_comb begin
    line_start  = (bus.hcount_in == 11'd0);
    frame_start = line_start && (bus.vcount_in == 10'd0);

    // A frame start uses the newly requested scale in the same cycle.
    scale_d = scale_q;
    sync_d  = sync_q;
    if (frame_start) begin
      sync_d  = 1'b1;
      scale_d = (bus.scale_in == 2'd3) ? 2'd1 : bus.scale_in + 2'd1;
    end
    s_last = scale_d - 2'd1;

    case (scale_d)
      2'd2:    begin h_lim = 12'(HL2); v_lim = 11'(VL2); end
      2'd3:    begin h_lim = 12'(HL3); v_lim = 11'(VL3); end
      default: begin h_lim = 12'(HL1); v_lim = 11'(VL1); end
    endcase
    in_region = sync_d && (12'(bus.hcount_in) < h_lim) && (11'(bus.vcount_in) < v_lim);

    row_d  = row_q;
    rsub_d = rsub_q;
    base_d = base_q;
    if (line_start) begin
      if (bus.vcount_in == 10'd0) begin
        row_d  = '0;
        rsub_d = '0;
        base_d = '0;
      end else if (rsub_q >= s_last) begin
        rsub_d = '0;
        if (row_q < ROW_MAX) begin
          row_d  = row_q + 10'd1;
          base_d = base_q + LINE_STEP;
        end
      end else begin
        rsub_d = rsub_q + 2'd1;
      end
    end

    col_cur  = line_start ? 11'd0 : col_q;
    csub_cur = line_start ? 2'd0  : csub_q;
    col_d    = col_cur;
    csub_d   = csub_cur;
    if (in_region) begin
      if (csub_cur >= s_last) begin
        csub_d = '0;
        col_d  = col_cur + 11'd1;
      end else begin
        csub_d = csub_cur + 2'd1;
      end
    end

    // Counter bounds keep the address inside the source frame even for broken raster sequences.
    addr_d = (in_region && (col_cur < COL_MAX) && (row_d < ROW_MAX))
           ? base_d + ADDR_W'(col_cur) : '0;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      scale_q   <= 2'd1;
      sync_q    <= 1'b0;
      col_q     <= '0;
      csub_q    <= '0;
      row_q     <= '0;
      rsub_q    <= '0;
      base_q    <= '0;
      addr_q    <= '0;
      vld_dly_q <= '0;
      h_dly_q   <= '0;
      v_dly_q   <= '0;
      cam_q     <= '0;
      cam_vld_q <= 1'b0;
      hout_q    <= '0;
      vout_q    <= '0;
    end else begin
      scale_q   <= scale_d;
      sync_q    <= sync_d;
      col_q     <= col_d;
      csub_q    <= csub_d;
      row_q     <= row_d;
      rsub_q    <= rsub_d;
      base_q    <= base_d;
      addr_q    <= addr_d;
      vld_dly_q <= {vld_dly_q[RD_LAT-1:0], in_region};
      h_dly_q   <= {h_dly_q[RD_LAT-1:0], (sync_d ? bus.hcount_in : 11'd0)};
      v_dly_q   <= {v_dly_q[RD_LAT-1:0], (sync_d ? bus.vcount_in : 10'd0)};
      // Last delay stage lines up with the frame-buffer data for the same pixel.
      cam_q     <= vld_dly_q[RD_LAT] ? bus.frame_buff_in : '0;
      cam_vld_q <= vld_dly_q[RD_LAT];
      hout_q    <= h_dly_q[RD_LAT];
      vout_q    <= v_dly_q[RD_LAT];
    end
  end

  assign bus.addr_out      = addr_q;
  assign bus.cam_out       = cam_q;
  assign bus.cam_valid_out = cam_vld_q;
  assign bus.hcount_out    = hout_q;
  assign bus.vcount_out    = vout_q;

endmodule
